vga_line_buffer: RTL

- Ping-pong line buffer that sits directly upstream of the 320x480 VGA timing/colour stage. Runs in the clk12 domain.
- A pixel producer (pattern engine, or HPS bridge) writes one 6-bit RRGGBB line at a time through a valid/ready handshake.
- The VGA stage signals the start of each visible line, then pulls pixels one per clock.
- The buffer decouples the producer's bursty writes from the strict scan-out rate, and flags underruns.

---
 rtl/vga_line_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer between the pixel producer and the VGA scan-out stage (clk12 domain).
// Optional feature macro VGA_LB_REPEAT_EN: a finished line is held and re-displayed on underrun.
module vga_line_buffer #(
    parameter int LINE_PIXELS = 320,
    parameter int PIX_W       = 6,
    parameter int ADDR_W      = 9
) (
    input  logic             clk12,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             line_start,
    input  logic             rd_en,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             underrun,
    output logic             line_err,
    input  logic             clr_flags
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int MEM_AW = $clog2(2 * LINE_PIXELS);

    typedef enum logic [2:0] {B_EMPTY, B_FILLING, B_FULL, B_READING, B_HELD} bank_t;

    logic [PIX_W-1:0]  r_mem [0:2*LINE_PIXELS-1];
    bank_t             r_bank_st [0:1];
    logic [CNT_W-1:0]  r_cnt [0:1];
    logic              r_wbank;
    logic [ADDR_W-1:0] r_wptr;
    logic [CNT_W-1:0]  r_rptr;
    logic              r_rbank;
    logic              r_rsel;
    logic              r_in_ready;
    logic              r_rd_valid;
    logic              r_rd_zero;
    logic [PIX_W-1:0]  r_rd_q;
    logic              r_underrun;
    logic              r_line_err;

    bank_t             w_bank_nx [0:1];
    logic              w_wbank_nx;
    logic              w_ready_nx;
    logic              w_wr, w_last_addr, w_close, w_len_err;
    logic              w_rd, w_rd_end;
    logic              w_full0, w_full1, w_any_full;
    logic              w_sel_bank, w_sel_ok;
    logic [MEM_AW-1:0] w_waddr, w_raddr;

    assign w_wr        = in_valid & r_in_ready;
    assign w_last_addr = (r_wptr == ADDR_W'(LINE_PIXELS - 1));
    assign w_close     = w_wr & (in_last | w_last_addr);
    assign w_len_err   = w_wr & (in_last ^ w_last_addr);
    assign w_rd        = rd_en & r_rsel & ~line_start;
    assign w_rd_end    = w_rd & (r_rptr == CNT_W'(LINE_PIXELS - 1));
    assign w_full0     = (r_bank_st[0] == B_FULL);
    assign w_full1     = (r_bank_st[1] == B_FULL);
    assign w_any_full  = w_full0 | w_full1;

    // With both banks full the write bank has wrapped round to the older line.
`ifdef VGA_LB_REPEAT_EN
    logic w_held0, w_held1;
    assign w_held0    = (r_bank_st[0] == B_HELD);
    assign w_held1    = (r_bank_st[1] == B_HELD);
    assign w_sel_bank = w_any_full ? ((w_full0 & w_full1) ? r_wbank : w_full1) : w_held1;
    assign w_sel_ok   = w_any_full | w_held0 | w_held1;
`else
    assign w_sel_bank = (w_full0 & w_full1) ? r_wbank : w_full1;
    assign w_sel_ok   = w_any_full;
`endif

    assign w_waddr = MEM_AW'(r_wptr) + (r_wbank ? MEM_AW'(LINE_PIXELS) : MEM_AW'(0));
    assign w_raddr = MEM_AW'(r_rptr) + (r_rbank ? MEM_AW'(LINE_PIXELS) : MEM_AW'(0));

    always_comb begin
        w_bank_nx[0] = r_bank_st[0];
        w_bank_nx[1] = r_bank_st[1];
        w_wbank_nx   = r_wbank;
        if (w_wr) begin
            if (w_close) begin
                w_bank_nx[r_wbank] = B_FULL;
                w_wbank_nx         = ~r_wbank;
            end else begin
                w_bank_nx[r_wbank] = B_FILLING;
            end
        end
        if (w_rd_end) begin
`ifdef VGA_LB_REPEAT_EN
            w_bank_nx[r_rbank] = B_HELD;
`else
            w_bank_nx[r_rbank] = B_EMPTY;
`endif
        end
        if (line_start) begin
            if (r_bank_st[0] == B_READING) w_bank_nx[0] = B_EMPTY;
            if (r_bank_st[1] == B_READING) w_bank_nx[1] = B_EMPTY;
`ifdef VGA_LB_REPEAT_EN
            if (w_any_full && w_held0) w_bank_nx[0] = B_EMPTY;
            if (w_any_full && w_held1) w_bank_nx[1] = B_EMPTY;
`endif
            if (w_sel_ok) w_bank_nx[w_sel_bank] = B_READING;
        end
        w_ready_nx = (w_bank_nx[w_wbank_nx] == B_EMPTY) || (w_bank_nx[w_wbank_nx] == B_FILLING);
    end

    always_ff @(posedge clk12 or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
            r_cnt[0]     <= '0;
            r_cnt[1]     <= '0;
            r_wbank      <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rbank      <= 1'b0;
            r_rsel       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_rd_valid   <= 1'b0;
            r_rd_zero    <= 1'b1;
            r_underrun   <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            r_bank_st[0] <= w_bank_nx[0];
            r_bank_st[1] <= w_bank_nx[1];
            r_wbank      <= w_wbank_nx;
            r_in_ready   <= w_ready_nx;
            if (w_wr) begin
                r_wptr <= w_close ? '0 : r_wptr + ADDR_W'(1);
                if (w_close) r_cnt[r_wbank] <= CNT_W'(r_wptr) + CNT_W'(1);
            end
            r_rd_valid <= rd_en;
            // Pixels past the written count, blank lines and idle reads all come out black.
            r_rd_zero  <= ~(w_rd && (r_rptr < r_cnt[r_rbank]));
            if (line_start) begin
                r_rsel  <= w_sel_ok;
                r_rbank <= w_sel_bank;
                r_rptr  <= '0;
            end else if (w_rd) begin
                r_rptr <= r_rptr + CNT_W'(1);
                if (w_rd_end) r_rsel <= 1'b0;
            end
            if (clr_flags) begin
                r_underrun <= 1'b0;
                r_line_err <= 1'b0;
            end else begin
                if (line_start && !w_any_full) r_underrun <= 1'b1;
                if (w_len_err) r_line_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk12) begin
        if (w_wr) r_mem[w_waddr] <= in_data;
        if (w_rd) r_rd_q <= r_mem[w_raddr];
    end

    assign in_ready = r_in_ready;
    assign rd_data  = r_rd_zero ? '0 : r_rd_q;
    assign rd_valid = r_rd_valid;
    assign underrun = r_underrun;
    assign line_err = r_line_err;

endmodule
